// File: rtl/ks_control_unit.sv
// K&S 16-bit processor control unit.
// Moore FSM sequencing fetch / decode / execute. Every output is a register
// loaded with the value belonging to the state being entered, so outputs
// depend only on the current state and never combinationally on inputs.

package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_ADD    = 4'd1,
        I_SUB    = 4'd2,
        I_AND    = 4'd3,
        I_OR     = 4'd4,
        I_MOVE   = 4'd5,
        I_LOAD   = 4'd6,
        I_STORE  = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNEG   = 4'd10,
        I_HALT   = 4'd11
    } decoded_instruction_type;
endpackage

module ks_control_unit
    import k_and_s_pkg::*;
#(
    parameter int MEM_LATENCY = 2,   // 1..7
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic [CNT_W-1:0]        retired_count
);

    // Last value of the wait counter before the RAM data is valid.
    localparam logic [2:0] WAIT_LAST = 3'(MEM_LATENCY - 1);

    // Branch resolution is folded into two states so the PC strobes remain a
    // pure function of state. The flags are registered in the datapath and
    // only move in EXEC_ALU, so the value seen while dispatching from DECODE
    // is the value present during the branch cycle.
    typedef enum logic [3:0] {
        S_FETCH,
        S_LOAD_IR,
        S_DECODE,
        S_EXEC_ALU,
        S_EXEC_MOVE,
        S_MEM_LD,
        S_MEM_ST,
        S_LOAD_WB,
        S_STORE_WR,
        S_BR_TAKEN,
        S_BR_NOT,
        S_RETIRE,
        S_HALT
    } state_t;

    state_t     state;
    logic [2:0] wait_cnt;

    // State transitions plus registered outputs for the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_FETCH;
            wait_cnt         <= 3'd0;
            retired_count    <= '0;
            branch           <= 1'b0;
            pc_enable        <= 1'b0;
            ir_enable        <= 1'b0;
            addr_sel         <= 1'b0;
            c_sel            <= 1'b0;
            operation        <= 2'b00;
            write_reg_enable <= 1'b0;
            flags_reg_enable <= 1'b0;
            ram_write_enable <= 1'b0;
            halt             <= 1'b0;
        end else begin
            // Everything idles unless the entered state raises it below.
            branch           <= 1'b0;
            pc_enable        <= 1'b0;
            ir_enable        <= 1'b0;
            addr_sel         <= 1'b0;
            c_sel            <= 1'b0;
            operation        <= 2'b00;
            write_reg_enable <= 1'b0;
            flags_reg_enable <= 1'b0;
            ram_write_enable <= 1'b0;
            halt             <= 1'b0;

            case (state)
                S_FETCH: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt  <= 3'd0;
                        state     <= S_LOAD_IR;
                        ir_enable <= 1'b1;
                        pc_enable <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end

                S_LOAD_IR: state <= S_DECODE;

                S_DECODE: begin
                    case (decoded_instruction)
                        I_ADD, I_SUB, I_AND, I_OR: begin
                            state            <= S_EXEC_ALU;
                            write_reg_enable <= 1'b1;
                            flags_reg_enable <= 1'b1;
                            case (decoded_instruction)
                                I_ADD:   operation <= 2'b01;
                                I_SUB:   operation <= 2'b10;
                                I_AND:   operation <= 2'b11;
                                default: operation <= 2'b00;
                            endcase
                        end
                        I_MOVE: begin
                            // a|a passes the source through; flags untouched.
                            state            <= S_EXEC_MOVE;
                            write_reg_enable <= 1'b1;
                        end
                        I_LOAD: begin
                            state    <= S_MEM_LD;
                            addr_sel <= 1'b1;
                        end
                        I_STORE: begin
                            state    <= S_MEM_ST;
                            addr_sel <= 1'b1;
                        end
                        I_BRANCH, I_BZERO, I_BNEG: begin
                            if (decoded_instruction == I_BRANCH ||
                                (decoded_instruction == I_BZERO && zero_op) ||
                                (decoded_instruction == I_BNEG  && neg_op)) begin
                                state     <= S_BR_TAKEN;
                                pc_enable <= 1'b1;
                                branch    <= 1'b1;
                            end else begin
                                state <= S_BR_NOT;
                            end
                        end
                        I_HALT: begin
                            state <= S_HALT;
                            halt  <= 1'b1;
                        end
                        default: state <= S_RETIRE;
                    endcase
                end

                S_MEM_LD: begin
                    addr_sel <= 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt         <= 3'd0;
                        state            <= S_LOAD_WB;
                        c_sel            <= 1'b1;
                        write_reg_enable <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end

                S_MEM_ST: begin
                    addr_sel <= 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt         <= 3'd0;
                        state            <= S_STORE_WR;
                        ram_write_enable <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end

                S_EXEC_ALU, S_EXEC_MOVE, S_LOAD_WB, S_STORE_WR,
                S_BR_TAKEN, S_BR_NOT: state <= S_RETIRE;

                S_RETIRE: begin
                    state         <= S_FETCH;
                    retired_count <= retired_count + CNT_W'(1);
                end

                S_HALT: halt <= 1'b1;

                default: begin
                    state    <= S_FETCH;
                    wait_cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule
